// File: rtl/vend_pkg.sv
// vend_pkg: shared states and coin values for the vending coin feeder.
package vend_pkg;
  typedef enum logic [2:0] {IDLE, COIN, GAP, WAIT, DONE} feeder_state_t;
  localparam int COIN5_UNITS = 1;
  localparam int COIN10_UNITS = 2;
endpackage

// File: rtl/vend_gap_timer.sv
// vend_gap_timer: loadable down-counter that parks at zero and flags it.
module vend_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  always_comb cnt_d = load ? load_val : (zero ? cnt_q : cnt_q - W'(1));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/vend_coin_feeder.sv
// vend_coin_feeder: pays PRICE_UNITS with Rs5/Rs10 pulses and reports the vending outcome.
// Define VEND_FEEDER_EXACT_EN to forbid Rs10 when it would overpay.
module vend_coin_feeder
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS  = 3,
  parameter int COIN_GAP     = 2,
  parameter int RESP_TIMEOUT = 8,
  parameter int WALLET_W     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [WALLET_W-1:0] amount,
  input  logic                use_10,
  input  logic                item1,
  input  logic                rs5out,
  output logic                rs5,
  output logic                rs10,
  output logic                busy,
  output logic                done,
  output logic                got_item,
  output logic                got_change,
  output logic                short_funds,
  output logic                timeout,
  output logic [WALLET_W-1:0] coins_spent
);
  localparam int TMAX = (COIN_GAP > RESP_TIMEOUT) ? COIN_GAP : RESP_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = WALLET_W + 1;
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE_UNITS);
  localparam logic [TW-1:0] GAP_LD = TW'(COIN_GAP - 1);
  localparam logic [TW-1:0] RESP_LD = TW'(RESP_TIMEOUT - 1);

  feeder_state_t state_q, state_d;
  logic [WALLET_W-1:0] budget_q, budget_d, spent_q, spent_d, units;
  logic [CW-1:0] credit_q, credit_d;
  logic use10_q, use10_d, rs5_q, rs5_d, rs10_q, rs10_d, busy_q, busy_d, done_q, done_d;
  logic item_q, item_d, change_q, change_d, short_q, short_d, to_q, to_d;
  logic take10, tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;

`ifdef VEND_FEEDER_EXACT_EN
  assign take10 = use10_q && budget_q >= WALLET_W'(COIN10_UNITS) &&
                  (PRICE_C - credit_q) >= CW'(COIN10_UNITS);
`else
  assign take10 = use10_q && budget_q >= WALLET_W'(COIN10_UNITS);
`endif
  assign units = take10 ? WALLET_W'(COIN10_UNITS) : WALLET_W'(COIN5_UNITS);

  vend_gap_timer #(.W(TW)) u_timer (
    .clk(clk), .reset_n(reset_n), .load(tmr_load), .load_val(tmr_val), .zero(tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    budget_d = budget_q;
    credit_d = credit_q;
    spent_d = spent_q;
    use10_d = use10_q;
    rs5_d = 1'b0;
    rs10_d = 1'b0;
    item_d = item_q;
    change_d = change_q;
    short_d = short_q;
    to_d = to_q;
    tmr_load = 1'b0;
    tmr_val = GAP_LD;
    case (state_q)
      IDLE: if (start) begin
        budget_d = amount;
        use10_d = use_10;
        credit_d = '0;
        spent_d = '0;
        {item_d, change_d, to_d} = '0;
        short_d = amount == '0;
        state_d = (amount == '0) ? DONE : COIN;
      end
      COIN: begin
        rs10_d = take10;
        rs5_d = !take10;
        credit_d = credit_q + CW'(units);
        spent_d = spent_q + units;
        budget_d = budget_q - units;
        tmr_load = 1'b1;
        state_d = GAP;
      end
      GAP: if (tmr_zero) begin
        if (credit_q >= PRICE_C) begin
          tmr_load = 1'b1;
          tmr_val = RESP_LD;
          state_d = WAIT;
        end else if (budget_q == '0) begin
          short_d = 1'b1;
          state_d = DONE;
        end else state_d = COIN;
      end
      WAIT: if (item1) begin
        item_d = 1'b1;
        change_d = rs5out;
        state_d = DONE;
      end else if (tmr_zero) begin
        to_d = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      budget_q <= '0;
      credit_q <= '0;
      spent_q <= '0;
      use10_q <= 1'b0;
      rs5_q <= 1'b0;
      rs10_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      item_q <= 1'b0;
      change_q <= 1'b0;
      short_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      budget_q <= budget_d;
      credit_q <= credit_d;
      spent_q <= spent_d;
      use10_q <= use10_d;
      rs5_q <= rs5_d;
      rs10_q <= rs10_d;
      busy_q <= busy_d;
      done_q <= done_d;
      item_q <= item_d;
      change_q <= change_d;
      short_q <= short_d;
      to_q <= to_d;
    end

  assign rs5 = rs5_q;
  assign rs10 = rs10_q;
  assign busy = busy_q;
  assign done = done_q;
  assign got_item = item_q;
  assign got_change = change_q;
  assign short_funds = short_q;
  assign timeout = to_q;
  assign coins_spent = spent_q;
endmodule

// File: tb/tb_vend_coin_feeder.sv
// tb_vend_coin_feeder: table vectors, random transactions against a payment model, reset and re-start sequences.
module tb_vend_coin_feeder;
  localparam int PRICE = 3, GAP = 2, TO = 8;

  logic clk = 0, reset_n = 0, start = 0, use_10 = 0, item1 = 0, rs5out = 0;
  logic [3:0] amount = 0;
  logic rs5, rs10, busy, done, got_item, got_change, short_funds, timeout;
  logic [3:0] coins_spent;
  int checks = 0, errors = 0;

  vend_coin_feeder #(.PRICE_UNITS(PRICE), .COIN_GAP(GAP), .RESP_TIMEOUT(TO), .WALLET_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .amount(amount), .use_10(use_10),
    .item1(item1), .rs5out(rs5out), .rs5(rs5), .rs10(rs10), .busy(busy), .done(done),
    .got_item(got_item), .got_change(got_change), .short_funds(short_funds),
    .timeout(timeout), .coins_spent(coins_spent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] amt;
    bit u10;
    int k;
    bit chg;
    int restart;
    logic [3:0] spent;
    bit item, chg_o, short_f, to;
  } vec_t;

  // k: cycles after the last coin before item1 is raised (held), -1 = never
  task automatic run_txn(input string nm, input logic [3:0] amt, input bit u10, input int k,
                         input bit chg, input int restart, input bit use_model,
                         input logic [3:0] e_spent, input bit e_item, input bit e_chg,
                         input bit e_short, input bit e_to);
    int exp_c[$], got_c[$];
    bit exp_t[$], got_t[$];
    int credit = 0, budget = int'(amt), p = 0, s, done_at, done_c = -1, c = 0;
    bit ten, both = 0;
    logic [3:0] f_at, f_after;
    logic [3:0] sp_at;
    logic busy_at = 0;
    while (credit < PRICE && budget > 0) begin
      ten = u10 && budget >= 2;
`ifdef VEND_FEEDER_EXACT_EN
      ten = ten && (PRICE - credit) >= 2;
`endif
      exp_t.push_back(ten);
      p = 2 + exp_c.size() * (GAP + 1);
      exp_c.push_back(p);
      credit += ten ? 2 : 1;
      budget -= ten ? 2 : 1;
    end
    s = (k > GAP) ? p + k : p + GAP;
    if (amt == 0) done_at = 1;
    else if (credit < PRICE) done_at = p + GAP;
    else if (k >= 0 && s < p + GAP + TO) done_at = s + 1;
    else done_at = p + GAP + TO;
    if (use_model) begin
      e_spent = 4'(credit);
      e_short = credit < PRICE;
      e_item = !e_short && k >= 0 && s < p + GAP + TO;
      e_chg = e_item && chg;
      e_to = !e_short && !e_item;
    end
    @(negedge clk);
    start = 1; amount = amt; use_10 = u10;
    while (done_c < 0 && c < 300) begin
      @(negedge clk);
      c++;
      if (rs5 || rs10) begin
        got_c.push_back(c);
        got_t.push_back(rs10);
        if (rs5 && rs10) both = 1;
      end
      if (done) begin
        done_c = c;
        busy_at = busy;
        f_at = {got_item, got_change, short_funds, timeout};
        sp_at = coins_spent;
      end
      start = (c == restart);
      if (start) amount = 4'd7;
      item1 = k >= 0 && c >= p + k;
      rs5out = item1 && chg;
    end
    start = 0; item1 = 0; rs5out = 0;
    chk({nm, " done_cycle"}, done_c, done_at);
    chk({nm, " coin_count"}, got_c.size(), exp_c.size());
    for (int i = 0; i < got_c.size() && i < exp_c.size(); i++)
      chk($sformatf("%s coin%0d cycle*2+is10", nm, i), got_c[i] * 2 + int'(got_t[i]),
          exp_c[i] * 2 + int'(exp_t[i]));
    chk({nm, " rs5_rs10_overlap"}, both, 0);
    chk({nm, " busy_at_done"}, busy_at, 1);
    chk({nm, " flags item,chg,short,to"}, f_at, {e_item, e_chg, e_short, e_to});
    chk({nm, " coins_spent"}, sp_at, e_spent);
    @(negedge clk);
    f_after = {got_item, got_change, short_funds, timeout};
    chk({nm, " after_done busy,done,flags,spent"}, {busy, done, f_after, coins_spent},
        {2'b00, e_item, e_chg, e_short, e_to, e_spent});
  endtask

  initial begin
    vec_t tbl[$];
    bit bad;
    bit c1;
    logic [3:0] s1;
`ifdef VEND_FEEDER_EXACT_EN
    c1 = 0; s1 = 3;
`else
    c1 = 1; s1 = 4;
`endif
    tbl.push_back('{4'd3, 1'b0, 0, 1'b0, -1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'd4, 1'b1, 0, c1, -1, s1, 1'b1, c1, 1'b0, 1'b0});
    tbl.push_back('{4'd2, 1'b0, 0, 1'b0, -1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'd3, 1'b0, -1, 1'b0, -1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'd0, 1'b1, 0, 1'b0, -1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'd3, 1'b0, 9, 1'b0, -1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'd3, 1'b0, 10, 1'b0, -1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'd3, 1'b0, 1, 1'b1, 4, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'd1, 1'b1, 0, 1'b0, -1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'd15, 1'b1, 0, c1, -1, s1, 1'b1, c1, 1'b0, 1'b0});
    tbl.push_back('{4'd2, 1'b1, 0, 1'b0, -1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0});

    #1;
    chk("reset_outputs", {rs5, rs10, busy, done, got_item, got_change, short_funds, timeout, coins_spent}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    foreach (tbl[i])
      run_txn($sformatf("vec%0d", i), tbl[i].amt, tbl[i].u10, tbl[i].k, tbl[i].chg, tbl[i].restart,
              0, tbl[i].spent, tbl[i].item, tbl[i].chg_o, tbl[i].short_f, tbl[i].to);

    @(negedge clk);
    start = 1; amount = 3; use_10 = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("pulse_before_reset", rs5, 1);
    reset_n = 0;
    #1;
    chk("reset_cuts rs5,busy", {rs5, busy}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rs5 || rs10 || busy || done) bad = 1;
    end
    chk("no_activity_after_reset", bad, 0);
    run_txn("post_reset", 4'd3, 1'b0, 0, 1'b0, -1, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++)
      run_txn($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1,
              1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
